// File: rtl/axi_rd_checker.sv
// Checks an MM2S read stream against an incrementing pattern (seed+k, full keep) and reports errors, length and stall faults.
// o_done pulses one cycle after the final handshake; o_tready is held high while CHECK/DRAIN is active and low otherwise.
module axi_rd_checker #(
    parameter int DATA_WIDTH   = 64,
    parameter int LENGTH_WIDTH = 9,
    parameter int TIMEOUT      = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [LENGTH_WIDTH-1:0] i_length,
    input  logic [DATA_WIDTH-1:0]   i_seed,
    input  logic [DATA_WIDTH-1:0]   i_tdata,
    input  logic [DATA_WIDTH/8-1:0] i_tkeep,
    input  logic                    i_tvalid,
    input  logic                    i_tlast,
    output logic                    o_tready,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_pass,
    output logic [15:0]             o_err_cnt,
    output logic [LENGTH_WIDTH-1:0] o_first_err_idx,
    output logic                    o_first_err_vld,
    output logic                    o_len_err,
    output logic                    o_timeout
);

    localparam int IDLE_WIDTH = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, CHECK, DRAIN, DONE} state_t;

    state_t                  state, state_nxt;
    logic [LENGTH_WIDTH-1:0] len_q, k, k_nxt;
    logic [DATA_WIDTH-1:0]   seed_q;
    logic [IDLE_WIDTH-1:0]   idle_cnt, idle_nxt;
    logic [15:0]             err_cnt_nxt;
    logic [LENGTH_WIDTH-1:0] first_idx_nxt;
    logic                    first_vld_nxt, len_err_nxt, timeout_nxt, pass_nxt;
    logic                    start_acc, beat, last_idx, mismatch, stall;

    assign o_tready = (state == CHECK) || (state == DRAIN);
    assign o_busy   = o_tready;
    assign o_done   = (state == DONE);

    assign beat     = i_tvalid && o_tready;
    assign last_idx = (k == len_q - LENGTH_WIDTH'(1));
    assign mismatch = (i_tdata != seed_q + DATA_WIDTH'(k)) || (i_tkeep != '1);
    // Firing one count early makes DONE land on the edge where the count would reach TIMEOUT.
    assign stall    = (idle_cnt == IDLE_WIDTH'(TIMEOUT - 1));

    always_comb begin
        state_nxt     = state;
        k_nxt         = k;
        idle_nxt      = idle_cnt;
        err_cnt_nxt   = o_err_cnt;
        first_idx_nxt = o_first_err_idx;
        first_vld_nxt = o_first_err_vld;
        len_err_nxt   = o_len_err;
        timeout_nxt   = o_timeout;
        pass_nxt      = o_pass;
        start_acc     = 1'b0;
        case (state)
            IDLE: begin
                if (i_start && (i_length != '0)) begin
                    start_acc     = 1'b1;
                    state_nxt     = CHECK;
                    k_nxt         = '0;
                    idle_nxt      = '0;
                    err_cnt_nxt   = '0;
                    first_idx_nxt = '0;
                    first_vld_nxt = 1'b0;
                    len_err_nxt   = 1'b0;
                    timeout_nxt   = 1'b0;
                    pass_nxt      = 1'b0;
                end
            end
            CHECK: begin
                if (beat) begin
                    idle_nxt = '0;
                    k_nxt    = k + LENGTH_WIDTH'(1);
                    if (mismatch) begin
                        if (o_err_cnt != 16'hFFFF) begin
                            err_cnt_nxt = o_err_cnt + 16'd1;
                        end
                        if (!o_first_err_vld) begin
                            first_idx_nxt = k;
                            first_vld_nxt = 1'b1;
                        end
                    end
                    if (i_tlast) begin
                        len_err_nxt = !last_idx;
                        state_nxt   = DONE;
                    end else if (last_idx) begin
                        len_err_nxt = 1'b1;
                        state_nxt   = DRAIN;
                    end
                end else if (stall) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = DONE;
                end else begin
                    idle_nxt = idle_cnt + IDLE_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (beat) begin
                    idle_nxt = '0;
                    if (i_tlast) begin
                        state_nxt = DONE;
                    end
                end else if (stall) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = DONE;
                end else begin
                    idle_nxt = idle_cnt + IDLE_WIDTH'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // Verdict is captured on entry to DONE so it is already valid alongside o_done.
        if ((state != DONE) && (state_nxt == DONE)) begin
            pass_nxt = (err_cnt_nxt == '0) && !len_err_nxt && !timeout_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            k               <= '0;
            idle_cnt        <= '0;
            len_q           <= '0;
            seed_q          <= '0;
            o_err_cnt       <= '0;
            o_first_err_idx <= '0;
            o_first_err_vld <= 1'b0;
            o_len_err       <= 1'b0;
            o_timeout       <= 1'b0;
            o_pass          <= 1'b0;
        end else begin
            state           <= state_nxt;
            k               <= k_nxt;
            idle_cnt        <= idle_nxt;
            o_err_cnt       <= err_cnt_nxt;
            o_first_err_idx <= first_idx_nxt;
            o_first_err_vld <= first_vld_nxt;
            o_len_err       <= len_err_nxt;
            o_timeout       <= timeout_nxt;
            o_pass          <= pass_nxt;
            if (start_acc) begin
                len_q  <= i_length;
                seed_q <= i_seed;
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_checker.sv
// Directed bench for axi_rd_checker: inputs driven and outputs sampled on the falling clock edge.
module tb_axi_rd_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [8:0]  i_length;
    logic [63:0] i_seed;
    logic [63:0] i_tdata;
    logic [7:0]  i_tkeep;
    logic        i_tvalid;
    logic        i_tlast;
    logic        o_tready, o_busy, o_done, o_pass;
    logic [15:0] o_err_cnt;
    logic [8:0]  o_first_err_idx;
    logic        o_first_err_vld, o_len_err, o_timeout;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int n_acc  = 0;

    axi_rd_checker #(
        .DATA_WIDTH  (64),
        .LENGTH_WIDTH(9),
        .TIMEOUT     (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_start),
        .i_length       (i_length),
        .i_seed         (i_seed),
        .i_tdata        (i_tdata),
        .i_tkeep        (i_tkeep),
        .i_tvalid       (i_tvalid),
        .i_tlast        (i_tlast),
        .o_tready       (o_tready),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_pass         (o_pass),
        .o_err_cnt      (o_err_cnt),
        .o_first_err_idx(o_first_err_idx),
        .o_first_err_vld(o_first_err_vld),
        .o_len_err      (o_len_err),
        .o_timeout      (o_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start(input logic [8:0] len, input logic [63:0] seed);
        i_start  = 1'b1;
        i_length = len;
        i_seed   = seed;
        tick();
        i_start  = 1'b0;
    endtask

    task automatic beat(input logic [63:0] d, input logic [7:0] kp, input logic l);
        i_tdata  = d;
        i_tkeep  = kp;
        i_tlast  = l;
        i_tvalid = 1'b1;
        if (o_tready) n_acc++;
        tick();
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    initial begin
        int cyc;
        int seen_done, seen_rdy;
        logic [63:0] s;
        rst = 1'b1; i_start = 1'b0; i_length = '0; i_seed = '0;
        i_tdata = '0; i_tkeep = '0; i_tvalid = 1'b0; i_tlast = 1'b0;
        tick(); tick();
        rst = 1'b0;

        chk("rst_tready", o_tready, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_pass", o_pass, 0);
        chk("rst_err_cnt", o_err_cnt, 0);
        chk("rst_first_vld", o_first_err_vld, 0);
        chk("rst_len_err", o_len_err, 0);
        chk("rst_timeout", o_timeout, 0);

        // Clean burst of four beats
        start(4, 64'h100);
        chk("clean_busy", o_busy, 1);
        chk("clean_tready", o_tready, 1);
        beat(64'h100, 8'hFF, 0);
        beat(64'h101, 8'hFF, 0);
        beat(64'h102, 8'hFF, 0);
        chk("clean_no_early_done", o_done, 0);
        beat(64'h103, 8'hFF, 1);
        chk("clean_done", o_done, 1);
        chk("clean_pass", o_pass, 1);
        chk("clean_err_cnt", o_err_cnt, 0);
        chk("clean_len_err", o_len_err, 0);
        tick();
        chk("clean_done_1cyc", o_done, 0);
        chk("clean_idle_tready", o_tready, 0);
        chk("clean_pass_hold", o_pass, 1);

        // Eight beats: data error on beat 2, keep error on beat 5
        start(8, 64'h2000);
        for (int k = 0; k < 8; k++) begin
            s = 64'h2000 + 64'(k);
            if (k == 2) s = s ^ 64'hFF;
            beat(s, (k == 5) ? 8'h7F : 8'hFF, k == 7);
        end
        chk("corrupt_done", o_done, 1);
        chk("corrupt_err_cnt", o_err_cnt, 2);
        chk("corrupt_first_idx", o_first_err_idx, 2);
        chk("corrupt_first_vld", o_first_err_vld, 1);
        chk("corrupt_pass", o_pass, 0);
        tick(); tick(); tick();
        chk("corrupt_err_hold", o_err_cnt, 2);
        chk("corrupt_idx_hold", o_first_err_idx, 2);

        // Short burst: tlast on beat 1 of 4
        start(4, 64'h0);
        beat(64'h0, 8'hFF, 0);
        beat(64'h1, 8'hFF, 1);
        chk("short_done", o_done, 1);
        chk("short_len_err", o_len_err, 1);
        chk("short_err_cnt", o_err_cnt, 0);
        chk("short_pass", o_pass, 0);
        tick();

        // Long burst: tlast on beat 6 of 4; drain beats carry junk data
        start(4, 64'h50);
        n_acc = 0;
        for (int k = 0; k < 7; k++) begin
            beat((k < 4) ? 64'h50 + 64'(k) : 64'hDEAD, 8'hFF, k == 6);
            if (k == 5) chk("long_busy_drain", o_busy, 1);
        end
        chk("long_accepted", n_acc, 7);
        chk("long_done", o_done, 1);
        chk("long_len_err", o_len_err, 1);
        chk("long_drain_unchecked", o_err_cnt, 0);
        tick();

        // Stall after two beats of four
        start(4, 64'h10);
        beat(64'h10, 8'hFF, 0);
        beat(64'h11, 8'hFF, 0);
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            if (o_done) break;
            cyc = i;
            tick();
        end
        chk("stall_done_seen", o_done, 1);
        chk("stall_cycles", cyc, 16);
        chk("stall_timeout", o_timeout, 1);
        chk("stall_pass", o_pass, 0);
        tick();

        // Zero-length start is ignored and leaves the previous results intact
        start(0, 64'h77);
        chk("zero_len_busy", o_busy, 0);
        chk("zero_len_tready", o_tready, 0);
        chk("zero_len_timeout_hold", o_timeout, 1);

        // Start while busy is ignored: length 2 and seed 0x300 remain in force
        start(2, 64'h300);
        beat(64'h300, 8'hFF, 0);
        i_start = 1'b1; i_length = 9'd5; i_seed = 64'h999;
        beat(64'h301, 8'hFF, 1);
        i_start = 1'b0;
        chk("busy_start_done", o_done, 1);
        chk("busy_start_pass", o_pass, 1);
        tick();

        // Reset mid-burst aborts without a done pulse; stray beats are refused
        start(4, 64'h400);
        beat(64'h400, 8'hFF, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", o_busy, 0);
        chk("midrst_tready", o_tready, 0);
        chk("midrst_err_cnt", o_err_cnt, 0);
        seen_done = 0;
        seen_rdy  = 0;
        i_tvalid = 1'b1; i_tdata = 64'h401; i_tkeep = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            if (o_done) seen_done++;
            if (o_tready) seen_rdy++;
            tick();
        end
        i_tvalid = 1'b0;
        chk("midrst_no_done", seen_done, 0);
        chk("midrst_no_ready", seen_rdy, 0);

        // All-ones seed wraps to zero on beat 1
        start(2, 64'hFFFF_FFFF_FFFF_FFFF);
        beat(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
        beat(64'h0, 8'hFF, 1);
        chk("wrap_done", o_done, 1);
        chk("wrap_pass", o_pass, 1);
        chk("wrap_err_cnt", o_err_cnt, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axi_rd_checker.md
AXI_RD_CHECKER -- requirements
Module: axi_rd_checker

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, read-stream data width in bits.
REQ-002 SHALL have parameter LENGTH_WIDTH, default 9, width of the beat-count field.
REQ-003 SHALL have parameter TIMEOUT, default 1024, maximum idle cycles between accepted beats.
REQ-004 SHALL have ports clk input 1, clock; rst input 1, reset. Reset is synchronous and active-high; all logic is clocked on the rising edge of clk.
REQ-005 SHALL have ports i_start input 1, arm pulse; i_length input LENGTH_WIDTH, expected beats; i_seed input DATA_WIDTH, data value of beat 0.
REQ-006 SHALL have ports i_tdata input DATA_WIDTH, i_tkeep input DATA_WIDTH/8, i_tvalid input 1, i_tlast input 1, o_tready output 1, forming the MM2S read stream.
REQ-007 SHALL have ports o_busy output 1, check in progress; o_done output 1, single-cycle completion pulse; o_pass output 1, verdict.
REQ-008 SHALL have ports o_err_cnt output 16, data/keep mismatch count; o_first_err_idx output LENGTH_WIDTH, first bad beat index; o_first_err_vld output 1.
REQ-009 SHALL have ports o_len_err output 1, tlast misplaced; o_timeout output 1, stream stalled.

Function
REQ-010 SHALL implement states IDLE, CHECK, DRAIN and DONE.
REQ-011 In IDLE, i_start=1 with i_length!=0 SHALL latch i_length and i_seed, clear all result outputs, zero the beat index k, and go to CHECK next cycle.
REQ-012 i_start with i_length=0 SHALL be ignored, leaving the FSM in IDLE.
REQ-013 i_start outside IDLE SHALL be ignored.
REQ-014 o_tready SHALL be 1 in CHECK and DRAIN and 0 in IDLE and DONE; a beat is accepted when i_tvalid & o_tready.
REQ-015 Expected data for beat k SHALL be seed+k modulo 2^DATA_WIDTH; expected keep SHALL be all ones.
REQ-016 In CHECK, each accepted beat whose data or keep mismatches SHALL increment o_err_cnt once; the count saturates at 16'hFFFF.
REQ-017 On the first mismatch, o_first_err_idx SHALL take k and o_first_err_vld SHALL be set; both hold until the next accepted start.
REQ-018 If an accepted beat with k=length-1 has i_tlast=1, the FSM SHALL go to DONE.
REQ-019 If an accepted beat with k=length-1 has i_tlast=0, the block SHALL set o_len_err and go to DRAIN.
REQ-020 If an accepted beat with k<length-1 has i_tlast=1, the block SHALL set o_len_err and go to DONE (short burst); that beat's data is still checked.
REQ-021 In DRAIN, beats SHALL be consumed without data checking until an accepted beat with i_tlast=1, then the FSM goes to DONE.
REQ-022 An idle counter SHALL clear on every accepted beat and on entry to CHECK, and increment in CHECK/DRAIN otherwise.
REQ-023 When the idle counter reaches TIMEOUT, the block SHALL set o_timeout and go to DONE.
REQ-024 DONE SHALL last exactly one cycle, drive o_done=1 and return to IDLE.
REQ-025 The o_done pulse SHALL occur the cycle after the final accepted beat's handshake.
REQ-026 o_pass SHALL be registered in DONE as (o_err_cnt==0)&~o_len_err&~o_timeout, and hold until the next accepted start.
REQ-027 o_busy SHALL be 1 in CHECK and DRAIN.
REQ-028 The beat index k SHALL be LENGTH_WIDTH bits and never wraps within a legal burst.
REQ-029 Result outputs SHALL remain stable from o_done until the next accepted start.

Reset
REQ-030 rst=1 SHALL force IDLE and o_tready=0, and clear o_busy, o_done, o_pass, o_err_cnt, o_first_err_idx, o_first_err_vld, o_len_err, o_timeout and the idle counter, all on the next clk edge.
REQ-031 rst asserted mid-burst SHALL abort the check without an o_done pulse; stray beats after reset are not accepted until re-armed.

Verification
REQ-032 Clean burst: seed=64'h100, length=4, beats 100..103 with tlast on the 4th beat -> o_done one cycle later, o_pass=1, o_err_cnt=0.
REQ-033 Data corruption: length=8, beats 2 and 5 corrupted -> o_err_cnt=2, o_first_err_idx=2, o_first_err_vld=1, o_pass=0.
REQ-034 Short/long burst: length=4 with tlast on beat 1 -> o_len_err=1, done after beat 1; length=4 with tlast on beat 6 -> 7 beats accepted, then o_len_err=1, o_done.
REQ-035 Stall: TIMEOUT=16, length=4, only 2 beats sent -> o_timeout=1 and o_done 16 cycles after beat 2, o_pass=0.
REQ-036 Control corners: i_length=0 start -> stays IDLE; start while busy -> ignored; rst mid-burst -> IDLE, o_tready=0, no o_done; seed=all-ones, length=2 -> expected beat 1 wraps to 0, pass.
